// File: rtl/proj_frag_collector.sv
// proj_frag_collector: reassembles LSB-first FRAG_PART-bit slices into FRAG_LEN-bit fragments and queues {index, fragment} records.
// Define PROJ_COLLECT_IDX_CHECK_EN to add the sticky idx_err index-consistency flag.
module proj_frag_collector #(
    parameter int FRAG_LEN   = 8,
    parameter int FRAG_PART  = 2,
    parameter int INDICE_LEN = 5,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [INDICE_LEN-1:0]   in_index,
    input  logic [FRAG_PART-1:0]    in_gfm,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [INDICE_LEN-1:0]   out_index,
    output logic [FRAG_LEN-1:0]     out_fragment,
    output logic [$clog2(DEPTH):0]  out_count,
    output logic                    overflow
`ifdef PROJ_COLLECT_IDX_CHECK_EN
    ,
    output logic                    idx_err
`endif
);
    localparam int FRAG_PARTS_COUNT = FRAG_LEN / FRAG_PART;
    localparam int PART_BITS = (FRAG_PARTS_COUNT > 1) ? $clog2(FRAG_PARTS_COUNT) : 1;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PART_BITS-1:0] LAST = PART_BITS'(FRAG_PARTS_COUNT - 1);

    logic [PART_BITS-1:0]  part_q, part_d;
    logic [FRAG_LEN-1:0]   asm_q, asm_d, asm_mix;
    logic [INDICE_LEN-1:0] idx_q, idx_d, rec_idx;
    logic [PW-1:0]         wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    logic                  done, first, full, pop, push;
    logic [INDICE_LEN-1:0] mem_idx [DEPTH];
    logic [FRAG_LEN-1:0]   mem_frag [DEPTH];

    always_comb begin
        asm_mix = asm_q;
        asm_mix[FRAG_PART*int'(part_q) +: FRAG_PART] = in_gfm;
    end

    assign first   = (part_q == '0);
    assign done    = in_valid & (part_q == LAST);
    assign part_d  = in_valid ? (done ? '0 : part_q + PART_BITS'(1)) : part_q;
    assign asm_d   = in_valid ? asm_mix : asm_q;
    assign idx_d   = (in_valid && first) ? in_index : idx_q;
    // A single-slice fragment completes on its first beat, so the live index is used.
    assign rec_idx = first ? in_index : idx_q;

    assign full  = (cnt_q == CW'(DEPTH));
    assign pop   = out_valid & out_ready;
    assign push  = done & (~full | pop);
    assign wr_d  = push ? wr_q + PW'(1) : wr_q;
    assign rd_d  = pop ? rd_q + PW'(1) : rd_q;
    assign cnt_d = cnt_q + CW'(push) - CW'(pop);
    assign ovf_d = ovf_q | (done & full & ~pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            part_q <= '0;
            asm_q  <= '0;
            idx_q  <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            part_q <= part_d;
            asm_q  <= asm_d;
            idx_q  <= idx_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_idx[wr_q]  <= rec_idx;
            mem_frag[wr_q] <= asm_mix;
        end
    end

    // Storage is not reset, so the head is masked while the FIFO is empty.
    assign out_valid    = (cnt_q != '0);
    assign out_index    = out_valid ? mem_idx[rd_q] : '0;
    assign out_fragment = out_valid ? mem_frag[rd_q] : '0;
    assign out_count    = cnt_q;
    assign overflow     = ovf_q;

`ifdef PROJ_COLLECT_IDX_CHECK_EN
    logic ierr_q, ierr_d;
    assign ierr_d = ierr_q | (in_valid & ~first & (in_index != idx_q));
    always_ff @(posedge clk) begin
        if (!rst_n) ierr_q <= 1'b0;
        else        ierr_q <= ierr_d;
    end
    assign idx_err = ierr_q;
`endif
endmodule
